// File: rtl/dma_periph_requester.sv
// dma_periph_requester
//   Device-side agent for an 8237A-style DREQ/DACK handshake, single channel,
//   device-to-memory direction. A local producer fills an internal FIFO. The
//   block raises DREQ when enough data is buffered. It presents the FIFO head
//   on the data bus during acknowledged I/O-read cycles. Terminal count (EOP)
//   parks the agent in DONE until software clears it.
//
// Ports
//   CLK, RESET_N      clock; synchronous active-low reset
//   enable            allows new requests (does not abort an acknowledged one)
//   mode              00 demand, 01 single, 10 block, 11 demand
//   dreq_low          DREQ pin is active-low when 1
//   dack_low          DACK pin is active-low when 1
//   wr_en, wr_data    producer push port
//   DREQ              request to the DMA controller
//   DACK              acknowledge from the DMA controller
//   IOR_N             I/O read strobe (active low); its rising edge pops a word
//   EOP_N             end of process / terminal count (active low)
//   DB_out, DB_oe     data bus drive and its output enable
//   tc_clr            clears done, xfer_count, overflow, underflow
//   done              terminal count seen (sticky)
//   overflow          push attempted while full (sticky)
//   underflow         read strobe while empty (sticky)
//   fifo_level        FIFO occupancy
//   xfer_count        number of completed pops (wraps)
module dma_periph_requester #(
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int BLOCK_THRESH = 4,
   parameter int CNT_W        = 16
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          enable,
   input  logic [1:0]                    mode,
   input  logic                          dreq_low,
   input  logic                          dack_low,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          DREQ,
   input  logic                          DACK,
   input  logic                          IOR_N,
   input  logic                          EOP_N,
   output logic [DATA_W-1:0]             DB_out,
   output logic                          DB_oe,
   input  logic                          tc_clr,
   output logic                          done,
   output logic                          overflow,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              xfer_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] THRESH = LW'(BLOCK_THRESH);
   localparam logic [LW-1:0] DEPTH  = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_GAP, S_DONE} state_t;

   state_t              state, state_nxt;
   logic                req_i, req_d;
   logic                ack_p1, ior_n_p1, ior_n_p2, eop_n_p1;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [LW-1:0]       wr_ptr, rd_ptr, level_nxt;
   logic                full, empty, ior_rise, pop, push, rd_empty, eop_evt;
   logic                mode_single, mode_block, cond;

   // ---- stage p1: register the DMA-side pins (ack already polarity-corrected)
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         ack_p1   <= 1'b0;
         ior_n_p1 <= 1'b1;
         ior_n_p2 <= 1'b1;
         eop_n_p1 <= 1'b1;
      end else begin
         ack_p1   <= DACK ^ dack_low;
         ior_n_p1 <= IOR_N;
         ior_n_p2 <= ior_n_p1;
         eop_n_p1 <= EOP_N;
      end
   end

   assign mode_single = (mode == 2'b01);
   assign mode_block  = (mode == 2'b10);

   assign fifo_level = wr_ptr - rd_ptr;
   assign full       = (fifo_level == DEPTH);
   assign empty      = (fifo_level == '0);
   assign ior_rise   = ior_n_p1 & ~ior_n_p2;
   assign pop        = ack_p1 & ior_rise & ~empty;
   assign rd_empty   = ack_p1 & ior_rise & empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push       = wr_en & (~full | pop);
   assign level_nxt  = fifo_level + LW'(push) - LW'(pop);
   assign eop_evt    = ack_p1 & ~eop_n_p1;
   assign cond       = mode_block ? (fifo_level >= THRESH) : ~empty;

   // ---- FIFO storage and pointers
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // ---- sticky flags and transfer counter; tc_clr beats a same-cycle pop
   always_ff @(posedge CLK) begin
      if (!RESET_N || tc_clr) begin
         xfer_count <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (pop)          xfer_count <= xfer_count + CNT_W'(1);
         if (wr_en & full) overflow   <= 1'b1;
         if (rd_empty)     underflow  <= 1'b1;
      end
   end

   // ---- FSM: state register (req_i is registered alongside the state)
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state <= S_IDLE;
         req_i <= 1'b0;
      end else begin
         state <= state_nxt;
         req_i <= req_d;
      end
   end

   // ---- FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (eop_evt)               state_nxt = S_DONE;
            else if (enable && cond)   state_nxt = S_REQ;
         end
         S_REQ: begin
            if (eop_evt)               state_nxt = S_DONE;
            else if (ack_p1)           state_nxt = S_XFER;
            else if (!enable)          state_nxt = S_IDLE;
         end
         S_XFER: begin
            if (eop_evt)
               state_nxt = S_DONE;
            else if (!ack_p1)          // controller withdrew acknowledge
               state_nxt = mode_single ? S_GAP : (cond ? S_REQ : S_IDLE);
            else if (mode_single && pop)
               state_nxt = S_GAP;
            else if (!mode_single && !mode_block && pop && level_nxt == '0)
               state_nxt = S_IDLE;
         end
         S_GAP:                        state_nxt = eop_evt ? S_DONE : S_IDLE;
         S_DONE: begin
            if (tc_clr)                state_nxt = S_IDLE;
         end
         default:                      state_nxt = S_IDLE;
      endcase
   end

   // ---- FSM: outputs
   always_comb begin
      req_d  = (state_nxt == S_REQ) || (state_nxt == S_XFER && !mode_single);
      done   = (state == S_DONE);
      DB_oe  = ack_p1 & ~ior_n_p1;
      DB_out = (DB_oe && !empty) ? mem[rd_ptr[AW-1:0]] : '0;
   end

   assign DREQ = req_i ^ dreq_low;

endmodule

// File: tb/tb_dma_periph_requester.sv
// tb_dma_periph_requester
//   Directed bench for dma_periph_requester. A queue-based reference model of
//   the FIFO, sticky flags, counter and bus drive is compared against the DUT
//   on every cycle; DREQ behaviour and a few data values are pinned by
//   literal expectations in the stimulus.
module tb_dma_periph_requester;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        dreq_low = 1'b0;
   logic        dack_low = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        DREQ;
   logic        DACK = 1'b0;
   logic        IOR_N = 1'b1;
   logic        EOP_N = 1'b1;
   logic [7:0]  DB_out;
   logic        DB_oe;
   logic        tc_clr = 1'b0;
   logic        done, overflow, underflow;
   logic [3:0]  fifo_level;
   logic [15:0] xfer_count;

   int n_pass = 0;
   int n_total = 0;
   bit check_en = 1'b0;

   dma_periph_requester #(
      .DATA_W(8), .FIFO_DEPTH(8), .BLOCK_THRESH(4), .CNT_W(16)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .enable(enable), .mode(mode),
      .dreq_low(dreq_low), .dack_low(dack_low), .wr_en(wr_en), .wr_data(wr_data),
      .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .EOP_N(EOP_N),
      .DB_out(DB_out), .DB_oe(DB_oe), .tc_clr(tc_clr), .done(done),
      .overflow(overflow), .underflow(underflow), .fifo_level(fifo_level),
      .xfer_count(xfer_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: pins delayed as the block samples them, FIFO as a queue.
   logic [7:0]  mq[$];
   int unsigned m_cnt = 0;
   bit m_ovf = 0, m_unf = 0, m_done = 0;
   bit m_a1 = 0, m_i1 = 1, m_i2 = 1, m_e1 = 1;

   always @(posedge CLK) begin : model
      bit rise, do_pop, do_push, was_full;
      if (!RESET_N) begin
         mq.delete();
         m_cnt = 0; m_ovf = 0; m_unf = 0; m_done = 0;
         m_a1 = 0; m_i1 = 1; m_i2 = 1; m_e1 = 1;
      end else begin
         rise     = m_i1 && !m_i2;
         was_full = (mq.size() == 8);
         do_pop   = m_a1 && rise && (mq.size() > 0);
         do_push  = wr_en && (!was_full || do_pop);
         if (tc_clr) begin
            m_cnt = 0; m_ovf = 0; m_unf = 0;
         end else begin
            if (do_pop) m_cnt = (m_cnt + 1) % 65536;
            if (wr_en && was_full) m_ovf = 1;
            if (m_a1 && rise && mq.size() == 0) m_unf = 1;
         end
         if (m_done && tc_clr) m_done = 0;
         else if (!m_done && m_a1 && !m_e1) m_done = 1;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(wr_data);
         m_a1 = DACK ^ dack_low;
         m_i2 = m_i1;
         m_i1 = IOR_N;
         m_e1 = EOP_N;
      end
   end

   always @(posedge CLK) begin : compare
      logic       e_oe;
      logic [7:0] e_db;
      #1;
      if (check_en) begin
         e_oe = m_a1 && !m_i1;
         e_db = (e_oe && mq.size() > 0) ? mq[0] : 8'h00;
         chk("m_level", fifo_level, mq.size());
         chk("m_count", xfer_count, m_cnt);
         chk("m_overflow", overflow, m_ovf);
         chk("m_underflow", underflow, m_unf);
         chk("m_done", done, m_done);
         chk("m_db_oe", DB_oe, e_oe);
         chk("m_db_out", DB_out, e_db);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // One read strobe: IOR_N low 2 cycles, high 2 cycles; returns the bus value.
   task automatic ior_pulse(output logic [7:0] db);
      IOR_N = 1'b0;
      @(negedge CLK);
      db = DB_out;
      @(negedge CLK);
      IOR_N = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic wait_dreq(input logic v, input string nm);
      int n = 0;
      while (DREQ !== v && n < 32) begin
         @(negedge CLK);
         n++;
      end
      chk(nm, DREQ, v);
   endtask

   initial begin
      logic [7:0] d;
      cyc(1);
      check_en = 1'b1;
      cyc(1);
      // reset state
      chk("rst_dreq", DREQ, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_count", xfer_count, 0);
      chk("rst_db_oe", DB_oe, 0);
      chk("rst_done", done, 0);
      RESET_N = 1'b1; enable = 1'b1; mode = 2'b00;
      cyc(1);

      // demand mode: three words, three reads
      wr_en = 1'b1; wr_data = 8'hA1; cyc(1);
      wr_data = 8'hA2; chk("dem_lat1", DREQ, 0); cyc(1);
      wr_data = 8'hA3; chk("dem_lat2", DREQ, 1); cyc(1);
      wr_en = 1'b0; DACK = 1'b1; cyc(3);
      ior_pulse(d); chk("dem_db1", d, 8'hA1);
      ior_pulse(d); chk("dem_db2", d, 8'hA2); chk("dem_req_held", DREQ, 1);
      ior_pulse(d); chk("dem_db3", d, 8'hA3); chk("dem_req_drop", DREQ, 0);
      chk("dem_count", xfer_count, 3);
      DACK = 1'b0; cyc(2);
      tc_clr = 1'b1; cyc(1); tc_clr = 1'b0;
      chk("clr_count", xfer_count, 0);

      // single mode: one pop per request, one-cycle gap
      mode = 2'b01;
      wr_en = 1'b1; wr_data = 8'hB1; cyc(1);
      wr_data = 8'hB2; cyc(1);
      wr_en = 1'b0;
      wait_dreq(1'b1, "sgl_req1");
      DACK = 1'b1; cyc(3);
      chk("sgl_xfer_req", DREQ, 0);
      ior_pulse(d); chk("sgl_db1", d, 8'hB1);
      chk("sgl_gap", DREQ, 0); cyc(1);
      chk("sgl_idle", DREQ, 0); cyc(1);
      chk("sgl_rereq", DREQ, 1);
      cyc(2);
      ior_pulse(d); chk("sgl_db2", d, 8'hB2);
      chk("sgl_count", xfer_count, 2);
      DACK = 1'b0; cyc(2);
      tc_clr = 1'b1; cyc(1); tc_clr = 1'b0;

      // block mode: threshold 4, EOP during the second read
      mode = 2'b10;
      wr_en = 1'b1; wr_data = 8'hC1; cyc(1);
      wr_data = 8'hC2; cyc(1);
      wr_data = 8'hC3; cyc(1);
      wr_en = 1'b0; cyc(4);
      chk("blk_below", DREQ, 0);
      chk("blk_level3", fifo_level, 3);
      wr_en = 1'b1; wr_data = 8'hC4; cyc(1);
      wr_en = 1'b0; chk("blk_lat1", DREQ, 0); cyc(1);
      chk("blk_lat2", DREQ, 1);
      DACK = 1'b1; cyc(3);
      ior_pulse(d); chk("blk_db1", d, 8'hC1); chk("blk_req_held", DREQ, 1);
      IOR_N = 1'b0; EOP_N = 1'b0; cyc(1);
      d = DB_out; cyc(1);
      IOR_N = 1'b1; EOP_N = 1'b1; cyc(2);
      chk("blk_db2", d, 8'hC2);
      chk("blk_done", done, 1);
      chk("blk_count", xfer_count, 2);
      chk("blk_done_req", DREQ, 0);
      wr_en = 1'b1; wr_data = 8'hC5; cyc(1);
      wr_data = 8'hC6; cyc(1);
      wr_en = 1'b0; DACK = 1'b0; cyc(4);
      chk("blk_done_hold", DREQ, 0);
      chk("blk_level4", fifo_level, 4);
      tc_clr = 1'b1; cyc(1); tc_clr = 1'b0;
      chk("blk_clr_done", done, 0);
      chk("blk_clr_count", xfer_count, 0);
      wait_dreq(1'b1, "blk_rereq");

      // inverted pin polarity
      RESET_N = 1'b0; dreq_low = 1'b1; dack_low = 1'b1; DACK = 1'b1; mode = 2'b00;
      cyc(2);
      chk("pol_rst_dreq", DREQ, 1);
      RESET_N = 1'b1; cyc(2);
      chk("pol_idle", DREQ, 1);
      wr_en = 1'b1; wr_data = 8'hD1; cyc(1);
      wr_en = 1'b0;
      wait_dreq(1'b0, "pol_req");
      DACK = 1'b0; cyc(3);
      ior_pulse(d); chk("pol_db", d, 8'hD1);
      chk("pol_drop", DREQ, 1);
      DACK = 1'b1; wr_en = 1'b1; wr_data = 8'hD2; cyc(1);
      wr_en = 1'b0;
      wait_dreq(1'b0, "pol_req2");
      RESET_N = 1'b0; cyc(1);
      chk("pol_rst2", DREQ, 1);
      chk("pol_rst2_level", fifo_level, 0);
      RESET_N = 1'b1; dreq_low = 1'b0; dack_low = 1'b0; DACK = 1'b0; enable = 1'b0;
      cyc(1);

      // overflow, push+pop at full, underflow
      wr_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'(8'hE0 + i);
         cyc(1);
      end
      wr_en = 1'b0;
      chk("ovf_flag", overflow, 1);
      chk("ovf_level", fifo_level, 8);
      tc_clr = 1'b1; cyc(1); tc_clr = 1'b0;
      chk("ovf_clr", overflow, 0);
      DACK = 1'b1; cyc(2);
      IOR_N = 1'b0; cyc(2);
      IOR_N = 1'b1; cyc(1);
      wr_en = 1'b1; wr_data = 8'hF0; cyc(1);
      wr_en = 1'b0;
      chk("full_pp_level", fifo_level, 8);
      chk("full_pp_ovf", overflow, 1);
      chk("full_pp_count", xfer_count, 1);
      ior_pulse(d); chk("full_pp_head", d, 8'hE1);
      RESET_N = 1'b0; DACK = 1'b0; cyc(2);
      RESET_N = 1'b1; DACK = 1'b1; cyc(2);
      ior_pulse(d);
      chk("unf_flag", underflow, 1);
      chk("unf_count", xfer_count, 0);
      chk("unf_level", fifo_level, 0);
      DACK = 1'b0; cyc(1);

      // reset in the middle of a transfer
      enable = 1'b1; mode = 2'b00; DACK = 1'b1; wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'hF1 + i);
         cyc(1);
      end
      wr_en = 1'b0; IOR_N = 1'b0; cyc(3);
      chk("mid_level", fifo_level, 5);
      chk("mid_db_oe", DB_oe, 1);
      chk("mid_dreq", DREQ, 1);
      RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; cyc(1);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_dreq", DREQ, 0);
      chk("mid_rst_db_oe", DB_oe, 0);
      RESET_N = 1'b1; cyc(3);

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
